// File: rtl/dma_write_controller.sv
// DMA write engine: reads device memory over AXI and forwards it as PCIe write TLPs.
// Optional macro DMA_WRITE_RRESP_CHECK_EN adds a sticky dma_write_error output.
module dma_write_controller #(
   parameter int unsigned p_max_payload = 512
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [15:0]  pcie_dcommand,
   input  logic [31:0]  dma_write_host_address,
   input  logic [31:0]  dma_write_device_address,
   input  logic [31:0]  dma_write_length,
   input  logic         dma_write_start,
   output logic [31:0]  dma_write_addr,
   output logic [9:0]   dma_write_len,
   output logic         dma_write_valid,
   input  logic         dma_write_done,
   output logic [127:0] dma_write_data,
   output logic         dma_write_data_valid,
   input  logic         dma_write_data_ready,
   output logic         int_valid,
   input  logic         int_done,
   output logic         busy,
   output logic [31:0]  araddr,
   output logic [7:0]   arlen,
   output logic [2:0]   arsize,
   output logic [1:0]   arburst,
   output logic [3:0]   arcache,
   output logic [2:0]   arprot,
   output logic         arvalid,
   input  logic         arready,
   input  logic [127:0] rdata,
   input  logic [1:0]   rresp,
   input  logic         rlast,
   input  logic         rvalid,
   output logic         rready
`ifdef DMA_WRITE_RRESP_CHECK_EN
   ,output logic        dma_write_error
`endif
);

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StCalc = 3'd1;
   localparam logic [2:0] StAr   = 3'd2;
   localparam logic [2:0] StHdr  = 3'd3;
   localparam logic [2:0] StData = 3'd4;
   localparam logic [2:0] StInt  = 3'd5;

   localparam logic [31:0] MaxPayload = 32'(p_max_payload);
   localparam logic [31:0] AlignMask  = 32'hFFFF_FFF0;

   logic [2:0]  state_q, state_d;
   logic [31:0] host_q, host_d;
   logic [31:0] dev_q, dev_d;
   logic [31:0] rem_q, rem_d;
   logic [12:0] chunk_q, chunk_d;

   logic [31:0] mps_raw, mps, host_room, dev_room, chunk_calc, chunk_ext, start_len;
   logic [8:0]  beats_m1;
   logic        in_data, beat_acc, last_acc;

   assign mps_raw   = 32'd128 << pcie_dcommand[7:5];
   assign mps       = (mps_raw > MaxPayload) ? MaxPayload : mps_raw;
   assign host_room = 32'd4096 - {20'd0, host_q[11:0]};
   assign dev_room  = 32'd4096 - {20'd0, dev_q[11:0]};
   assign chunk_ext = {19'd0, chunk_q};
   assign start_len = dma_write_length & AlignMask;
   assign beats_m1  = chunk_q[12:4] - 9'd1;

   // Smallest of remaining bytes, payload limit and both 4 KiB page limits.
   always_comb begin
      chunk_calc = rem_q;
      if (mps < chunk_calc)       chunk_calc = mps;
      if (host_room < chunk_calc) chunk_calc = host_room;
      if (dev_room < chunk_calc)  chunk_calc = dev_room;
   end

   assign in_data  = (state_q == StData);
   assign beat_acc = in_data && rvalid && dma_write_data_ready;
   assign last_acc = beat_acc && rlast;

   always_comb begin
      state_d = state_q;
      host_d  = host_q;
      dev_d   = dev_q;
      rem_d   = rem_q;
      chunk_d = chunk_q;
      case (state_q)
         StIdle: begin
            if (dma_write_start) begin
               host_d  = dma_write_host_address & AlignMask;
               dev_d   = dma_write_device_address & AlignMask;
               rem_d   = start_len;
               state_d = (start_len == 32'd0) ? StInt : StCalc;
            end
         end
         StCalc: begin
            chunk_d = chunk_calc[12:0];
            state_d = StAr;
         end
         StAr:   if (arready) state_d = StHdr;
         StHdr:  if (dma_write_done) state_d = StData;
         StData: begin
            if (last_acc) begin
               host_d  = host_q + chunk_ext;
               dev_d   = dev_q + chunk_ext;
               rem_d   = rem_q - chunk_ext;
               state_d = (rem_q == chunk_ext) ? StInt : StCalc;
            end
         end
         StInt:  if (int_done) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= StIdle;
         host_q  <= 32'd0;
         dev_q   <= 32'd0;
         rem_q   <= 32'd0;
         chunk_q <= 13'd0;
      end else begin
         state_q <= state_d;
         host_q  <= host_d;
         dev_q   <= dev_d;
         rem_q   <= rem_d;
         chunk_q <= chunk_d;
      end
   end

   always_comb begin
      busy                 = (state_q != StIdle);
      arvalid              = (state_q == StAr);
      araddr               = arvalid ? dev_q : 32'd0;
      arlen                = arvalid ? beats_m1[7:0] : 8'd0;
      arsize               = arvalid ? 3'b100 : 3'b000;
      arburst              = arvalid ? 2'b01 : 2'b00;
      arcache              = arvalid ? 4'b0011 : 4'b0000;
      arprot               = 3'b000;
      dma_write_valid      = (state_q == StHdr);
      dma_write_addr       = dma_write_valid ? host_q : 32'd0;
      dma_write_len        = dma_write_valid ? chunk_q[11:2] : 10'd0;
      // Straight pass-through: the TX side applies backpressure to the R channel directly.
      rready               = in_data && dma_write_data_ready;
      dma_write_data_valid = in_data && rvalid;
      dma_write_data       = in_data ? rdata : 128'd0;
      int_valid            = (state_q == StInt);
   end

`ifdef DMA_WRITE_RRESP_CHECK_EN
   logic error_q, error_d;

   always_comb begin
      error_d = error_q;
      if (state_q == StIdle && dma_write_start) error_d = 1'b0;
      if (beat_acc && rresp != 2'b00)           error_d = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) error_q <= 1'b0;
      else       error_q <= error_d;
   end

   assign dma_write_error = error_q;

   logic unused_cfg;
   assign unused_cfg = ^{pcie_dcommand[15:8], pcie_dcommand[4:0], beats_m1[8]};
`else
   logic unused_cfg;
   assign unused_cfg = ^{pcie_dcommand[15:8], pcie_dcommand[4:0], beats_m1[8], rresp};
`endif

endmodule

// File: tb/tb_dma_write_controller.sv
// Randomized bench for dma_write_controller: behavioural chunk model, AXI slave and TX sink.
module tb_dma_write_controller;

   localparam int unsigned PMax = 512;

   logic         i_clk = 1'b0;
   logic         i_rst;
   logic [15:0]  pcie_dcommand;
   logic [31:0]  dma_write_host_address, dma_write_device_address, dma_write_length;
   logic         dma_write_start;
   logic [31:0]  dma_write_addr;
   logic [9:0]   dma_write_len;
   logic         dma_write_valid, dma_write_done;
   logic [127:0] dma_write_data;
   logic         dma_write_data_valid, dma_write_data_ready;
   logic         int_valid, int_done, busy;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic [2:0]   arsize, arprot;
   logic [1:0]   arburst, rresp;
   logic [3:0]   arcache;
   logic         arvalid, arready;
   logic [127:0] rdata;
   logic         rlast, rvalid, rready;
`ifdef DMA_WRITE_RRESP_CHECK_EN
   logic         dma_write_error;
`endif

   always #5 i_clk = ~i_clk;

   dma_write_controller #(.p_max_payload(PMax)) u_dut (
      .i_clk                    (i_clk),
      .i_rst                    (i_rst),
      .pcie_dcommand            (pcie_dcommand),
      .dma_write_host_address   (dma_write_host_address),
      .dma_write_device_address (dma_write_device_address),
      .dma_write_length         (dma_write_length),
      .dma_write_start          (dma_write_start),
      .dma_write_addr           (dma_write_addr),
      .dma_write_len            (dma_write_len),
      .dma_write_valid          (dma_write_valid),
      .dma_write_done           (dma_write_done),
      .dma_write_data           (dma_write_data),
      .dma_write_data_valid     (dma_write_data_valid),
      .dma_write_data_ready     (dma_write_data_ready),
      .int_valid                (int_valid),
      .int_done                 (int_done),
      .busy                     (busy),
      .araddr                   (araddr),
      .arlen                    (arlen),
      .arsize                   (arsize),
      .arburst                  (arburst),
      .arcache                  (arcache),
      .arprot                   (arprot),
      .arvalid                  (arvalid),
      .arready                  (arready),
      .rdata                    (rdata),
      .rresp                    (rresp),
      .rlast                    (rlast),
      .rvalid                   (rvalid),
      .rready                   (rready)
`ifdef DMA_WRITE_RRESP_CHECK_EN
      ,.dma_write_error         (dma_write_error)
`endif
   );

   typedef struct {
      logic [31:0] host;
      logic [31:0] dev;
      int unsigned chunk;
   } chunk_t;

   chunk_t       exp_q[$];
   chunk_t       hdr_q[$];
   logic [127:0] gen_q[$];
   int           checks = 0;
   int           errors = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Splits a transfer into TLP-sized pieces straight from the page and payload rules.
   function automatic void build_model(input logic [31:0] host, input logic [31:0] dev,
                                       input logic [31:0] len, input logic [2:0] code);
      logic [31:0] h, d, rem;
      int unsigned mps, c, hroom, droom;
      chunk_t      e;
      h   = host & 32'hFFFF_FFF0;
      d   = dev & 32'hFFFF_FFF0;
      rem = len & 32'hFFFF_FFF0;
      mps = 128 << code;
      if (mps > PMax) mps = PMax;
      while (rem != 0) begin
         hroom = 4096 - (h % 4096);
         droom = 4096 - (d % 4096);
         c = rem;
         if (mps < c)   c = mps;
         if (hroom < c) c = hroom;
         if (droom < c) c = droom;
         e.host = h; e.dev = d; e.chunk = c;
         exp_q.push_back(e);
         h   = h + c;
         d   = d + c;
         rem = rem - c;
      end
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // mode 0: random handshakes; mode 1: always-ready AR/HDR, rvalid held, data_ready toggling.
   // abort_at >= 0 resets the DUT once that many beats have been accepted.
   task automatic run_xfer(input logic [31:0] host, input logic [31:0] dev,
                           input logic [31:0] len, input logic [2:0] code, input int mode,
                           input int abort_at, input int err_beat);
      int     beats_left = 0, accepted = 0, rx = 0, nbeats = 0, cyc = 0, ar_cnt = 0, nchunks;
      bit     done = 0, aborted = 0, in_data = 0, overlap = 0, tog = 0;
      chunk_t cur;
      logic [127:0] beat;
      exp_q.delete(); hdr_q.delete(); gen_q.delete();
      build_model(host, dev, len, code);
      nchunks = exp_q.size();
      foreach (exp_q[i]) nbeats += exp_q[i].chunk / 16;
      beat = '0;

      @(posedge i_clk); #1;
      pcie_dcommand            = {8'h00, code, 5'h00};
      dma_write_host_address   = host;
      dma_write_device_address = dev;
      dma_write_length         = len;
      dma_write_start          = 1'b1;
      #1 check("idle_busy", busy, 1'b0);
      @(posedge i_clk); #1;
      dma_write_start = 1'b0;

      while (!done && !aborted && cyc < 20000) begin
         tog = ~tog;
         arready              = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
         dma_write_done       = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
         dma_write_data_ready = (mode == 1) ? tog : 1'($urandom_range(0, 1));
         // Mid-transfer starts with fresh addresses must be ignored.
         dma_write_start          = 1'($urandom_range(0, 1));
         dma_write_host_address   = $urandom;
         dma_write_device_address = $urandom;
         dma_write_length         = $urandom;
         if (beats_left > 0) begin
            rvalid = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            rdata  = beat;
            rlast  = (beats_left == 1);
            rresp  = (accepted == err_beat - 1) ? 2'b10 : 2'b00;
         end else begin
            rvalid = 1'b0; rdata = rand128(); rlast = 1'b0; rresp = 2'b00;
         end
         #1;
         if (int_valid) begin
            done = 1;
            check("int_lat_len0", (nchunks == 0) ? 32'(cyc) : 32'd0, 32'd0);
         end else begin
            check("busy_active", busy, 1'b1);
            check("rready_gate", rready && !dma_write_data_ready, 1'b0);
            check("rready_phase", (rready || dma_write_data_valid) && !in_data, 1'b0);
            if (arvalid && beats_left > 0) overlap = 1;
            if (arvalid && arready) begin
               ar_cnt++;
               if (exp_q.size() == 0) check("ar_extra", 1'b1, 1'b0);
               else begin
                  cur = exp_q.pop_front();
                  check("araddr", araddr, cur.dev);
                  check("arlen", arlen, 8'(cur.chunk / 16 - 1));
                  check("ar_attr", {arsize, arburst, arcache, arprot},
                        {3'b100, 2'b01, 4'b0011, 3'b000});
                  hdr_q.push_back(cur);
                  beats_left = cur.chunk / 16;
                  beat = rand128();
                  gen_q.push_back(beat);
               end
            end
            if (dma_write_valid && dma_write_done) begin
               if (hdr_q.size() == 0) check("hdr_extra", 1'b1, 1'b0);
               else begin
                  cur = hdr_q.pop_front();
                  check("hdr_addr", dma_write_addr, cur.host);
                  check("hdr_len", dma_write_len, 10'(cur.chunk / 4));
                  in_data = 1;
               end
            end
            if (dma_write_data_valid && dma_write_data_ready) begin
               rx++;
               if (gen_q.size() == 0) check("data_extra", 1'b1, 1'b0);
               else check("data", dma_write_data, gen_q[0]);
            end
            if (rvalid && rready) begin
               if (gen_q.size() != 0) void'(gen_q.pop_front());
               accepted++;
               beats_left--;
               if (beats_left == 0) in_data = 0;
               else begin
                  beat = rand128();
                  gen_q.push_back(beat);
               end
               if (abort_at >= 0 && accepted == abort_at) aborted = 1;
            end
         end
         @(posedge i_clk); #1;
         cyc++;
      end
      dma_write_start = 1'b0;

      if (aborted) begin
         i_rst = 1'b1; rvalid = 1'b1; dma_write_data_ready = 1'b1;
         arready = 1'b1; dma_write_done = 1'b1;
         @(posedge i_clk); #1;
         i_rst = 1'b0;
         #1;
         check("rst_busy", busy, 1'b0);
         check("rst_outs", {arvalid, rready, dma_write_valid, dma_write_data_valid, int_valid},
               5'd0);
         check("rst_addrs", {araddr, arlen, dma_write_addr, dma_write_len}, '0);
         rvalid = 1'b0;
         return;
      end

      check("finished", done, 1'b1);
      check("no_overlap", overlap, 1'b0);
      check("ar_count", ar_cnt, nchunks);
      check("beats_in", accepted, nbeats);
      check("beats_out", rx, nbeats);
`ifdef DMA_WRITE_RRESP_CHECK_EN
      check("rresp_err", dma_write_error, (err_beat > 0 && err_beat <= nbeats) ? 1'b1 : 1'b0);
`endif
      if (done) begin
         for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
            @(posedge i_clk); #2;
            check("int_hold", int_valid, 1'b1);
         end
         @(posedge i_clk); #1;
         int_done = 1'b1;
         #1 check("int_valid", int_valid, 1'b1);
         @(posedge i_clk); #1;
         int_done = 1'b0;
         #1 check("int_clear", {int_valid, busy}, 2'b00);
      end
   endtask

   initial begin
      i_rst = 1'b1;
      pcie_dcommand = '0; dma_write_host_address = '0; dma_write_device_address = '0;
      dma_write_length = '0; dma_write_start = 1'b0; dma_write_done = 1'b0;
      dma_write_data_ready = 1'b0; int_done = 1'b0; arready = 1'b0;
      rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
      repeat (3) @(posedge i_clk);
      #1 i_rst = 1'b0;
      #1;
      check("reset_outs", {busy, arvalid, rready, dma_write_valid, dma_write_data_valid,
                           int_valid}, 6'd0);

      run_xfer(32'h0000_1000, 32'h0000_0000, 32'd256, 3'd0, 0, -1, 0);
      run_xfer(32'h0000_0FC0, 32'h0000_2000, 32'd128, 3'd2, 0, -1, 0);
      run_xfer(32'h0000_5000, 32'h0000_6000, 32'd0, 3'd2, 0, -1, 0);
      run_xfer(32'h0001_0000, 32'h0002_0F00, 32'd512, 3'd3, 1, -1, 0);
      run_xfer(32'hFFFF_FFC0, 32'h0000_0010, 32'd128, 3'd2, 0, -1, 0);
      run_xfer(32'h0000_3000, 32'h0000_4000, 32'd128, 3'd0, 0, 3, 0);
      run_xfer(32'h0000_7000, 32'h0000_8000, 32'd64, 3'd2, 0, -1, 0);
`ifdef DMA_WRITE_RRESP_CHECK_EN
      run_xfer(32'h0000_9000, 32'h0000_A000, 32'd128, 3'd2, 0, -1, 2);
      run_xfer(32'h0000_9000, 32'h0000_A000, 32'd64, 3'd2, 0, -1, 0);
`endif
      for (int t = 0; t < 10; t++) begin
         logic [31:0] h, d;
         h = $urandom;
         d = $urandom;
         if ($urandom_range(0, 1) == 1) h[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 1) d[11:0] = 12'hE00 | 12'($urandom_range(0, 511));
         run_xfer(h, d, 32'($urandom_range(0, 2048)), 3'($urandom_range(0, 7)),
                  int'($urandom_range(0, 1)), -1, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
